cache_arbiter: RTL and testbench

Two-port arbiter that shares the single device-side port of the SDRAM cache between the video fetcher (wopi, port 0) and the CPU (port 1). It latches the winning request, drives the cache request/ack handshake, captures read data, and returns a one-cycle ack to the requester. Port 0 has fixed priority. A burst limit guarantees the CPU a grant under sustained video traffic.

---
 rtl/cache_arbiter.sv | 133 +++++++++++++
 tb/tb_cache_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-port arbiter sharing the SDRAM cache device port between the video fetcher
// (port 0, fixed priority) and the CPU (port 1). A burst counter bounds how many
// consecutive port-0 grants may pass a waiting CPU request.
module cache_arbiter #(
  parameter int unsigned BURST_LIMIT = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [16:0] p0_address,
  input  logic [7:0]  p0_data_write,
  input  logic        p0_read_req,
  input  logic        p0_write_req,
  output logic [7:0]  p0_data_read,
  output logic        p0_read_ack,
  output logic        p0_write_ack,
  input  logic [16:0] p1_address,
  input  logic [7:0]  p1_data_write,
  input  logic        p1_read_req,
  input  logic        p1_write_req,
  output logic [7:0]  p1_data_read,
  output logic        p1_read_ack,
  output logic        p1_write_ack,
  output logic [16:0] cache_address,
  output logic [7:0]  cache_data_write,
  output logic        cache_read_req,
  output logic        cache_write_req,
  input  logic [7:0]  cache_data_read,
  input  logic        cache_read_ack,
  input  logic        cache_write_ack,
  output logic        grant,
  output logic        busy
);

  localparam logic [3:0] LimitCnt = 4'(BURST_LIMIT);
  localparam logic [3:0] CntMax   = 4'hF;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] burst_q;
  logic       is_read_q;

  logic p0_pend, p1_pend, any_pend, sel_p1, sel_read, take, match_ack;

  assign p0_pend  = p0_read_req | p0_write_req;
  assign p1_pend  = p1_read_req | p1_write_req;
  assign any_pend = p0_pend | p1_pend;
  // CPU wins when alone, or when the video port has used up its burst allowance.
  assign sel_p1   = p1_pend &
                    (~p0_pend | ((BURST_LIMIT != 0) && (burst_q == LimitCnt)));
  // Read has precedence when a port raises both request types.
  assign sel_read = sel_p1 ? p1_read_req : p0_read_req;
  assign take     = (state_q == StIdle) & any_pend;
  // Only the ack matching the issued type completes the transaction.
  assign match_ack = is_read_q ? cache_read_ack : cache_write_ack;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_pend) state_d = StIssue;
      StIssue: if (match_ack) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Port acks pulse for the single DONE cycle; busy covers ISSUE and DONE.
  always_comb begin
    busy         = (state_q != StIdle);
    p0_read_ack  = 1'b0;
    p0_write_ack = 1'b0;
    p1_read_ack  = 1'b0;
    p1_write_ack = 1'b0;
    if (state_q == StDone) begin
      p0_read_ack  = ~grant &  is_read_q;
      p0_write_ack = ~grant & ~is_read_q;
      p1_read_ack  =  grant &  is_read_q;
      p1_write_ack =  grant & ~is_read_q;
    end
  end

  // Latch the winning request and drive the cache handshake.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cache_address    <= '0;
      cache_data_write <= '0;
      cache_read_req   <= 1'b0;
      cache_write_req  <= 1'b0;
      grant            <= 1'b0;
      is_read_q        <= 1'b0;
    end else if (take) begin
      cache_address    <= sel_p1 ? p1_address : p0_address;
      cache_data_write <= sel_p1 ? p1_data_write : p0_data_write;
      cache_read_req   <= sel_read;
      cache_write_req  <= ~sel_read;
      grant            <= sel_p1;
      is_read_q        <= sel_read;
    end else if ((state_q == StIssue) && match_ack) begin
      // Address and write data stay put: the cache samples write data after its ack.
      cache_read_req  <= 1'b0;
      cache_write_req <= 1'b0;
    end
  end

  // Consecutive video grants taken while the CPU waits, saturating.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      burst_q <= '0;
    end else if (take) begin
      if (!sel_p1 && p1_pend) burst_q <= (burst_q == CntMax) ? CntMax : burst_q + 4'd1;
      else                    burst_q <= '0;
    end
  end

  // Per-port read data, updated only on that port's read completion.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      p0_data_read <= '0;
      p1_data_read <= '0;
    end else if ((state_q == StIssue) && match_ack && is_read_q) begin
      if (grant) p1_data_read <= cache_data_read;
      else       p0_data_read <= cache_data_read;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: a timestamp-based transaction model predicts every output
// each cycle, with directed scenarios and a randomized soak with sporadic resets.
module tb_cache_arbiter;

  localparam int unsigned BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [16:0] addr [2];
  logic [7:0]  wdat [2];
  logic        rd [2];
  logic        wr [2];
  logic [7:0]  dr0, dr1, c_wdat, c_rdata;
  logic        ra0, wa0, ra1, wa1, c_rreq, c_wreq, c_rack, c_wack, grant, busy;
  logic [16:0] c_addr;
  // Strict-priority instance outputs.
  logic [7:0]  s_dr0, s_dr1, s_wdat;
  logic        s_ra0, s_wa0, s_ra1, s_wa1, s_rreq, s_wreq, s_grant, s_busy;
  logic [16:0] s_addr;

  cache_arbiter #(.BURST_LIMIT(BL)) dut (
    .sys_clk(clk), .reset(reset),
    .p0_address(addr[0]), .p0_data_write(wdat[0]), .p0_read_req(rd[0]),
    .p0_write_req(wr[0]), .p0_data_read(dr0), .p0_read_ack(ra0), .p0_write_ack(wa0),
    .p1_address(addr[1]), .p1_data_write(wdat[1]), .p1_read_req(rd[1]),
    .p1_write_req(wr[1]), .p1_data_read(dr1), .p1_read_ack(ra1), .p1_write_ack(wa1),
    .cache_address(c_addr), .cache_data_write(c_wdat), .cache_read_req(c_rreq),
    .cache_write_req(c_wreq), .cache_data_read(c_rdata), .cache_read_ack(c_rack),
    .cache_write_ack(c_wack), .grant(grant), .busy(busy)
  );

  cache_arbiter #(.BURST_LIMIT(0)) dut_strict (
    .sys_clk(clk), .reset(reset),
    .p0_address(addr[0]), .p0_data_write(wdat[0]), .p0_read_req(rd[0]),
    .p0_write_req(wr[0]), .p0_data_read(s_dr0), .p0_read_ack(s_ra0), .p0_write_ack(s_wa0),
    .p1_address(addr[1]), .p1_data_write(wdat[1]), .p1_read_req(rd[1]),
    .p1_write_req(wr[1]), .p1_data_read(s_dr1), .p1_read_ack(s_ra1), .p1_write_ack(s_wa1),
    .cache_address(s_addr), .cache_data_write(s_wdat), .cache_read_req(s_rreq),
    .cache_write_req(s_wreq), .cache_data_read(c_rdata), .cache_read_ack(c_rack),
    .cache_write_ack(c_wack), .grant(s_grant), .busy(s_busy)
  );

  // Transaction model: a transaction is selected at the end of an idle cycle, the
  // request is visible from m_issue until the matching ack at cycle m_ack, and the
  // port ack falls in cycle m_ack+1.
  bit          m_active, m_read, m_grant;
  int          m_port, m_issue, m_ack, m_delay, m_burst;
  logic [16:0] m_addr;
  logic [7:0]  m_wdat;
  logic [7:0]  m_dr [2];

  bit done_flag [2];
  bit hold [2];
  bit rand_en, cache_auto;
  int stray_mode, dmax, cyc;
  int checks, failures;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] gv, ev;
    bit fin;
    fin = m_active && (m_ack >= 0);
    ev = {m_grant, m_active, m_active && m_read && (m_ack < 0),
          m_active && !m_read && (m_ack < 0),
          fin && m_port == 0 && m_read, fin && m_port == 0 && !m_read,
          fin && m_port == 1 && m_read, fin && m_port == 1 && !m_read};
    gv = {grant, busy, c_rreq, c_wreq, ra0, wa0, ra1, wa1};
    chk("ctl{grant,busy,rreq,wreq,a0r,a0w,a1r,a1w}", 32'(gv), 32'(ev));
    chk("cache_address", 32'(c_addr), 32'(m_addr));
    chk("cache_data_write", 32'(c_wdat), 32'(m_wdat));
    chk("p0_data_read", 32'(dr0), 32'(m_dr[0]));
    chk("p1_data_read", 32'(dr1), 32'(m_dr[1]));
  endtask

  task automatic new_req(input int p);
    int r;
    r = $urandom_range(7, 0);
    rd[p]   = (r < 4) || (r == 7);
    wr[p]   = (r >= 4);
    addr[p] = 17'($urandom);
    wdat[p] = 8'($urandom);
  endtask

  task automatic auto_req();
    for (int p = 0; p < 2; p++) begin
      if (done_flag[p]) begin
        done_flag[p] = 0;
        if (!hold[p]) begin
          if (rand_en && $urandom_range(3, 0) == 0) new_req(p);
          else begin rd[p] = 0; wr[p] = 0; end
        end
      end else if (rand_en && !rd[p] && !wr[p] && $urandom_range(2, 0) == 0) begin
        new_req(p);
      end
    end
  endtask

  task automatic auto_cache();
    if (!cache_auto) return;
    c_rack  = 0;
    c_wack  = 0;
    c_rdata = 8'($urandom);
    if (m_active && m_ack < 0 && cyc >= m_issue + 1) begin
      if (cyc >= m_issue + 1 + m_delay) begin
        if (m_read) c_rack = 1; else c_wack = 1;
      end
      if (stray_mode == 1 || (stray_mode == 2 && $urandom_range(3, 0) == 0)) begin
        if (m_read) c_wack = 1; else c_rack = 1;
      end
    end
  endtask

  task automatic model_edge();
    bit p0, p1;
    int sel;
    if (reset) begin
      m_active = 0; m_grant = 0; m_read = 0; m_ack = -1; m_burst = 0;
      m_addr = '0; m_wdat = '0; m_dr[0] = '0; m_dr[1] = '0;
    end else if (m_active) begin
      if (m_ack < 0) begin
        if (m_read ? c_rack : c_wack) begin
          m_ack = cyc;
          if (m_read) m_dr[m_port] = c_rdata;
        end
      end else begin
        m_active = 0;
        done_flag[m_port] = 1;
      end
    end else begin
      p0 = rd[0] | wr[0];
      p1 = rd[1] | wr[1];
      if (p0 || p1) begin
        sel = (p1 && (!p0 || (BL != 0 && m_burst == int'(BL)))) ? 1 : 0;
        if (sel == 0 && p1) m_burst = (m_burst < 15) ? m_burst + 1 : 15;
        else                m_burst = 0;
        m_port = sel; m_grant = (sel == 1); m_addr = addr[sel]; m_wdat = wdat[sel];
        m_read = rd[sel]; m_active = 1; m_issue = cyc + 1; m_ack = -1;
        m_delay = $urandom_range(dmax, 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    check_outputs();
    auto_req();
    auto_cache();
    model_edge();
    tick();
  endtask

  task automatic do_reset();
    reset = 1; cache_auto = 0; rand_en = 0; stray_mode = 0; dmax = 0;
    c_rack = 0; c_wack = 0; c_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      rd[p] = 0; wr[p] = 0; hold[p] = 0; done_flag[p] = 0; addr[p] = '0; wdat[p] = '0;
    end
    step();
    reset = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({grant, busy, c_rreq, c_wreq, ra0, wa0, ra1, wa1}), 32'h0);
    chk({tag, "_addr"}, 32'(c_addr), 32'h0);
    chk({tag, "_data"}, 32'({c_wdat, dr0, dr1}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, n_a, n_b, n_c, strict_p1, strict_acks;
    int seq[$];
    bit prev_rreq;
    checks = 0; failures = 0; cyc = 0;
    m_active = 0; m_grant = 0; m_read = 0; m_ack = -1; m_burst = 0; m_port = 0;
    m_issue = 0; m_delay = 0; m_addr = '0; m_wdat = '0; m_dr[0] = '0; m_dr[1] = '0;
    reset = 1;
    for (int p = 0; p < 2; p++) begin
      rd[p] = 0; wr[p] = 0; addr[p] = '0; wdat[p] = '0;
    end
    c_rack = 0; c_wack = 0; c_rdata = '0;
    tick();
    do_reset();
    chk_zero("reset");

    // Single CPU read of 0x00123, cache acks in cycle 2 with 0x5A.
    rd[1] = 1; addr[1] = 17'h00123;
    step();
    chk("t1_c1_rreq", 32'(c_rreq), 1);
    chk("t1_c1_addr", 32'(c_addr), 32'h00123);
    chk("t1_c1_grant", 32'(grant), 1);
    step();
    chk("t1_c2_rreq", 32'(c_rreq), 1);
    c_rack = 1; c_rdata = 8'h5A;
    step();
    c_rack = 0;
    chk("t1_c3_ack", 32'({ra1, wa1, ra0, wa0, c_rreq}), 32'b10000);
    chk("t1_c3_data", 32'(dr1), 32'h5A);
    chk("t1_c3_p0_data", 32'(dr0), 32'h0);
    step();
    chk("t1_c4_idle", 32'({busy, ra1}), 32'h0);

    // Read and write raised together on one port: read wins.
    do_reset();
    rd[1] = 1; wr[1] = 1; addr[1] = 17'h00010; cache_auto = 1;
    n_a = 0; n_b = 0; n_c = 0;
    for (int i = 0; i < 12; i++) begin
      if (ra1) n_a++;
      if (wa1) n_b++;
      if (c_wreq) n_c++;
      step();
    end
    chk("t6_read_acks", n_a, 1);
    chk("t6_write_acks", n_b, 0);
    chk("t6_write_req_cycles", n_c, 0);

    // Simultaneous video read and CPU write, with stray non-matching acks every cycle.
    do_reset();
    rd[0] = 1; addr[0] = 17'h1F000;
    wr[1] = 1; addr[1] = 17'h00040; wdat[1] = 8'hC3;
    cache_auto = 1; stray_mode = 1; dmax = 2;
    seq.delete(); n_a = 0; n_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (ra0) seq.push_back(0);
      if (wa1) begin
        seq.push_back(1);
        n_a++;
        chk("t2_wdata_hold", 32'(c_wdat), 32'hC3);
      end
      if (ra1) n_b++;
      step();
    end
    chk("t2_ack_count", seq.size(), 2);
    chk("t2_first_port", (seq.size() > 0) ? seq[0] : 9, 0);
    chk("t2_second_port", (seq.size() > 1) ? seq[1] : 9, 1);
    chk("t2_p1_write_acks", n_a, 1);
    chk("t2_p1_read_acks", n_b, 0);

    // Reset during ISSUE drops the transaction; the held request then restarts.
    do_reset();
    rd[1] = 1; addr[1] = 17'h00777;
    step();
    step();
    chk("t5_issue_rreq", 32'(c_rreq), 1);
    reset = 1;
    step();
    reset = 0;
    chk_zero("t5_after_reset");
    cache_auto = 1; dmax = 0; stray_mode = 0;
    t0 = cyc; lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (ra1 && lat < 0) lat = cyc - t0;
      step();
    end
    chk("t5_latency", lat, 3);

    // Sustained video traffic with the CPU waiting: 4 video grants then one CPU grant.
    do_reset();
    rd[0] = 1; rd[1] = 1; addr[0] = 17'h00100; addr[1] = 17'h00200;
    hold[0] = 1; hold[1] = 1; cache_auto = 1; dmax = 1;
    seq.delete(); prev_rreq = 0; strict_p1 = 0; strict_acks = 0;
    for (int i = 0; i < 80; i++) begin
      if (c_rreq && !prev_rreq) seq.push_back(int'(grant));
      prev_rreq = c_rreq;
      if (s_grant) strict_p1++;
      if (s_ra0) strict_acks++;
      step();
    end
    for (int i = 0; i < 10; i++)
      chk("burst_grant_seq", (i < seq.size()) ? seq[i] : 9, (i % 5 == 4) ? 1 : 0);
    chk("strict_p1_grants", strict_p1, 0);
    chk("strict_progress", 32'(strict_acks > 5), 1);

    // Randomized soak with occasional resets.
    do_reset();
    rand_en = 1; cache_auto = 1; stray_mode = 2; dmax = 3;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(399, 0) == 0);
      step();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
